// File: rtl/graph_pkg.sv
// Shared constants, state encoding and helpers for the piano-roll tile RAM writer.
package graph_pkg;

  localparam int unsigned TRACKS     = 49;
  localparam int unsigned COLS       = 64;
  localparam int unsigned INSTS      = 8;
  localparam int unsigned DRUM_TRACK = 48;

  localparam int unsigned ACT        = 0;
  localparam int unsigned BDR_BOTTOM = 1;
  localparam int unsigned BDR_TOP    = 2;

  localparam int unsigned WORD_W     = 3 * INSTS;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned COL_W      = 6;
  localparam int unsigned TRK_W      = 6;
  localparam int unsigned INST_W     = 3;
  localparam int unsigned RAM_WORDS  = COLS * TRACKS;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    COMMIT_PREV,
    COMMIT_CUR
  } state_t;

  typedef struct packed {
    logic [TRK_W-1:0]  track;
    logic [INST_W-1:0] inst;
    logic              on;
  } note_t;

  // First RAM address of a column.
  function automatic logic [ADDR_W-1:0] col_base(input logic [COL_W-1:0] c);
    return ADDR_W'(c) * ADDR_W'(TRACKS);
  endfunction

endpackage

// File: rtl/graph_word_pack.sv
// Packs per-instrument active / bottom-border / top-border bits into one tile word.
module graph_word_pack
  import graph_pkg::*;
(
  input  logic [INSTS-1:0]  act,
  input  logic [INSTS-1:0]  bdr_bot,
  input  logic [INSTS-1:0]  bdr_top,
  output logic [WORD_W-1:0] word
);

  for (genvar i = 0; i < INSTS; i++) begin : g_inst
    assign word[3*i+ACT]        = act[i];
    assign word[3*i+BDR_BOTTOM] = bdr_bot[i];
    assign word[3*i+BDR_TOP]    = bdr_top[i];
  end

endmodule

// File: rtl/graph_writer.sv
// Sequencer and sole writer of the piano-roll tile RAM; clears it after reset.
// Border bits and the previous-column rewrite exist only with GRAPH_WRITER_BORDER_EN.
module graph_writer
  import graph_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [TRK_W-1:0]  note_track,
  input  logic [INST_W-1:0] note_inst,
  input  logic              note_on,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [COL_W-1:0]  tile_offset,
  output logic              busy,
  output logic              overrun
);

  localparam logic [TRK_W-1:0]  K_LAST    = TRK_W'(TRACKS - 1);
  localparam logic [TRK_W-1:0]  TRK_MAX   = TRK_W'(DRUM_TRACK);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RAM_WORDS - 1);

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [TRK_W-1:0]  k;
  logic [INSTS-1:0]  held     [TRACKS];
  logic [INSTS-1:0]  tile_act [TRACKS];
  logic [INSTS-1:0]  snap     [TRACKS];
`ifdef GRAPH_WRITER_BORDER_EN
  logic [INSTS-1:0]  prev_act   [TRACKS];
  logic [INSTS-1:0]  prev_start [TRACKS];
`endif

  note_t             evt;
  logic [INSTS-1:0]  pk_act;
  logic [INSTS-1:0]  pk_bot;
  logic [INSTS-1:0]  pk_top;
  logic [WORD_W-1:0] pk_word;
  logic [ADDR_W-1:0] commit_addr;

  assign evt        = '{track: note_track, inst: note_inst, on: note_on};
  assign note_ready = (state == IDLE) && !tick;
  assign busy       = (state != IDLE);

  // Word and address for commit row k of the current phase.
  always_comb begin
    pk_act      = snap[k];
    pk_bot      = '0;
    pk_top      = '0;
    commit_addr = col_base(col) + ADDR_W'(k);
`ifdef GRAPH_WRITER_BORDER_EN
    if (state == COMMIT_PREV) begin
      pk_act      = prev_act[k];
      pk_bot      = prev_start[k];
      pk_top      = prev_act[k] & ~snap[k];
      commit_addr = col_base(col - COL_W'(1)) + ADDR_W'(k);
    end else begin
      pk_bot      = snap[k] & ~prev_act[k];
    end
`endif
  end

  graph_word_pack u_pack (
    .act     (pk_act),
    .bdr_bot (pk_bot),
    .bdr_top (pk_top),
    .word    (pk_word)
  );

  // Sequencer; wr_addr/wr_data hold between writes so the always-on RAM write is benign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      wr_addr     <= '0;
      wr_data     <= '0;
      tile_offset <= '0;
      col         <= '0;
      k           <= '0;
      overrun     <= 1'b0;
      for (int unsigned t = 0; t < TRACKS; t++) begin
        held[t]       <= '0;
        tile_act[t]   <= '0;
        snap[t]       <= '0;
`ifdef GRAPH_WRITER_BORDER_EN
        prev_act[t]   <= '0;
        prev_start[t] <= '0;
`endif
      end
    end else begin
      if (tick && (state == COMMIT_PREV || state == COMMIT_CUR)) begin
        overrun <= 1'b1;
      end
      case (state)
        INIT: begin
          wr_data <= '0;
          if (wr_addr == ADDR_LAST) begin
            state <= IDLE;
          end else begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (tick) begin
            for (int unsigned t = 0; t < TRACKS; t++) begin
              snap[t] <= tile_act[t];
            end
            k <= '0;
`ifdef GRAPH_WRITER_BORDER_EN
            state <= COMMIT_PREV;
`else
            state <= COMMIT_CUR;
`endif
          end else if (note_valid && evt.track <= TRK_MAX) begin
            held[evt.track][evt.inst] <= evt.on;
            if (evt.on) begin
              tile_act[evt.track][evt.inst] <= 1'b1;
            end
          end
        end
        COMMIT_PREV: begin
          wr_addr <= commit_addr;
          wr_data <= pk_word;
          if (k == K_LAST) begin
            k     <= '0;
            state <= COMMIT_CUR;
          end else begin
            k <= k + TRK_W'(1);
          end
        end
        COMMIT_CUR: begin
          wr_addr <= commit_addr;
          wr_data <= pk_word;
`ifdef GRAPH_WRITER_BORDER_EN
          prev_start[k] <= snap[k] & ~prev_act[k];
          prev_act[k]   <= snap[k];
`endif
          if (k == K_LAST) begin
            k           <= '0;
            col         <= col + COL_W'(1);
            tile_offset <= col + COL_W'(1);
            for (int unsigned t = 0; t < TRACKS; t++) begin
              tile_act[t] <= held[t];
            end
            state <= IDLE;
          end else begin
            k <= k + TRK_W'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_graph_writer.sv
// Randomized self-checking bench for graph_writer against a column-history reference model.
module tb_graph_writer;
  import graph_pkg::*;

  localparam int NWORDS = 3136;
`ifdef GRAPH_WRITER_BORDER_EN
  localparam int N_COMMIT = 98;
  localparam bit BORDER   = 1'b1;
`else
  localparam int N_COMMIT = 49;
  localparam bit BORDER   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [5:0]  note_track = '0;
  logic [2:0]  note_inst = '0;
  logic        note_on = 1'b0;
  logic [11:0] wr_addr;
  logic [23:0] wr_data;
  logic [5:0]  tile_offset;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] ram_dut [NWORDS];
  logic [23:0] ram_m   [NWORDS];
  logic [7:0]  held_m  [49];
  logic [7:0]  act_m   [49];
  logic [7:0]  hist    [64][49];
  int          col_m;
  bit          ovr_m;

  graph_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_track  (note_track),
    .note_inst   (note_inst),
    .note_on     (note_on),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .tile_offset (tile_offset),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: garbage while in reset, then one write per cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) ram_dut[i] <= 24'hA5A5A5;
    end else if (int'(wr_addr) < NWORDS) begin
      ram_dut[wr_addr] <= wr_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] pack(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    logic [23:0] w;
    for (int i = 0; i < 8; i++) begin
      w[3*i]   = a[i];
      w[3*i+1] = b[i];
      w[3*i+2] = c[i];
    end
    return w;
  endfunction

  task automatic ram_diff(output int bad);
    bad = 0;
    for (int i = 0; i < NWORDS; i++) if (ram_dut[i] !== ram_m[i]) bad++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NWORDS; i++) ram_m[i] = '0;
    for (int t = 0; t < 49; t++) begin
      held_m[t] = '0;
      act_m[t]  = '0;
      for (int c = 0; c < 64; c++) hist[c][t] = '0;
    end
    col_m = 0;
    ovr_m = 1'b0;
  endtask

  // Called right after rst_n rises on a negedge.
  task automatic run_init();
    int bad;
    bad = 0;
    for (int i = 0; i < NWORDS; i++) begin
      if (wr_addr !== 12'(i) || wr_data !== 24'h0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("init_seq", bad, 0);
    chk("init_busy_low", busy, 0);
    chk("init_ready", note_ready, 1);
    chk("init_offset", tile_offset, 0);
    model_reset();
    @(posedge clk);
    #1;
    ram_diff(bad);
    chk("init_ram", bad, 0);
  endtask

  task automatic send_note(input logic [5:0] trk, input logic [2:0] ins, input logic on);
    @(negedge clk);
    note_valid = 1'b1;
    note_track = trk;
    note_inst  = ins;
    note_on    = on;
    #1;
    chk("ready_idle", note_ready, 1);
    if (trk <= 6'd48) begin
      held_m[trk][ins] = on;
      if (on) act_m[trk][ins] = 1'b1;
    end
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic do_tick(input bit with_note, input bit with_ovr);
    int c, p, pp, n, bad;
    logic [7:0]  snap [49];
    logic [11:0] first_addr, exp_first;
    @(negedge clk);
    tick = 1'b1;
    if (with_note) begin
      note_valid = 1'b1;
      note_track = 6'd10;
      note_inst  = 3'd1;
      note_on    = 1'b1;
    end
    #1;
    chk("ready_tick", note_ready, 0);
    // reference commit: column history gives prev activity and starts
    c  = col_m;
    p  = (col_m + 63) % 64;
    pp = (col_m + 62) % 64;
    for (int t = 0; t < 49; t++) snap[t] = act_m[t];
    if (BORDER) begin
      for (int t = 0; t < 49; t++)
        ram_m[p*49+t] = pack(hist[p][t], hist[p][t] & ~hist[pp][t], hist[p][t] & ~snap[t]);
    end
    for (int t = 0; t < 49; t++) begin
      ram_m[c*49+t] = pack(snap[t], BORDER ? (snap[t] & ~hist[p][t]) : 8'h00, 8'h00);
      hist[c][t] = snap[t];
      act_m[t]   = held_m[t];
    end
    exp_first = BORDER ? 12'(p*49) : 12'(c*49);
    col_m = (col_m + 1) % 64;
    if (with_ovr) ovr_m = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    note_valid = 1'b0;
    n = 0;
    first_addr = '0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      if (n == 2) first_addr = wr_addr;
      tick = (with_ovr && n == 10);
      @(negedge clk);
    end
    tick = 1'b0;
    chk("commit_len", n, N_COMMIT);
    chk("first_addr", first_addr, exp_first);
    chk("tile_offset", tile_offset, col_m);
    chk("overrun", overrun, ovr_m);
    @(posedge clk);
    #1;
    ram_diff(bad);
    chk("ram_image", bad, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_ready", note_ready, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_offset", tile_offset, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    run_init();

    // key down on track 3 inst 2, drum key 5 tapped within the tile
    send_note(6'd3, 3'd2, 1'b1);
    send_note(6'd48, 3'd5, 1'b1);
    send_note(6'd48, 3'd5, 1'b0);
    do_tick(1'b0, 1'b0);
    chk("t1_addr3", ram_dut[3], BORDER ? 24'h0000C0 : 24'h000040);
    chk("t1_drum", ram_dut[48], BORDER ? 24'h018000 : 24'h008000);
    chk("t1_offset", tile_offset, 1);

    do_tick(1'b0, 1'b0);
    chk("t2_addr3", ram_dut[3], BORDER ? 24'h0000C0 : 24'h000040);
    chk("t2_addr52", ram_dut[52], 24'h000040);

    send_note(6'd3, 3'd2, 1'b0);
    do_tick(1'b0, 1'b0);
    chk("t3_addr52", ram_dut[52], 24'h000040);
    chk("t3_addr101", ram_dut[101], 24'h000040);

    do_tick(1'b0, 1'b0);
    chk("t4_addr101", ram_dut[101], BORDER ? 24'h000140 : 24'h000040);
    chk("t4_addr150", ram_dut[150], 24'h000000);

    // tick with a simultaneous note (tick wins) and a tick during commit
    do_tick(1'b1, 1'b1);

    // random traffic across the column wrap, including out-of-range tracks
    for (int r = 0; r < 62; r++) begin
      int nn;
      nn = $urandom_range(0, 4);
      for (int j = 0; j < nn; j++) begin
        send_note(6'($urandom_range(0, 55)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      do_tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    // reset in the middle of a commit
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1);
    chk("midrst_offset", tile_offset, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_addr", wr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_init();
    send_note(6'd5, 3'd0, 1'b1);
    do_tick(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
